// File: rtl/nlms_adaptive_filter.sv
// Sequential NLMS adaptive FIR: per accepted sample one coefficient-update pass,
// one circular-buffer write, then one filter pass over NUM_TAPS taps.
//
// state  | meaning
// IDLE   | waiting for ready_in or a clear request
// UPDATE | NUM_TAPS cycles, one NLMS coefficient update per cycle
// WRITE  | push new sample into the circular buffer, update running norm
// FILTER | NUM_TAPS cycles, one multiply-accumulate per cycle
// OUTPUT | register saturated y_out with done_out, dispatch pending clear
// CLEAR  | NUM_TAPS cycles, zero one coefficient per cycle
module nlms_adaptive_filter #(
  parameter int NUM_TAPS      = 64,
  parameter int DATA_W        = 16,
  parameter int COEFF_W       = 16,
  parameter int COEFF_FRAC    = 14,
  parameter int MU_SHIFT      = 4,
  parameter int NORM_MIN_LOG2 = 20,
  parameter int LEAK_SHIFT    = 12
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 ready_in,
  input  logic signed [DATA_W-1:0]             sample_in,
  input  logic signed [DATA_W-1:0]             error_in,
  input  logic                                 adapt_en_in,
  input  logic                                 leak_en_in,
  input  logic                                 clear_in,
  output logic signed [DATA_W-1:0]             y_out,
  output logic                                 done_out,
  output logic                                 busy_out,
  output logic                                 overrun_out,
  output logic                                 coeff_sat_out,
  output logic [2*DATA_W+$clog2(NUM_TAPS)-1:0] norm_out
);

  localparam int TAP_W  = $clog2(NUM_TAPS);
  localparam int NORM_W = 2*DATA_W + TAP_W;
  localparam int PROD_W = 2*DATA_W;
  localparam int UPD_W  = ((PROD_W > COEFF_W) ? PROD_W : COEFF_W) + 2;
  localparam int MAC_W  = DATA_W + COEFF_W;
  localparam int ACC_W  = MAC_W + TAP_W;

  localparam logic signed [UPD_W-1:0] W_MAX = {{(UPD_W-COEFF_W+1){1'b0}}, {(COEFF_W-1){1'b1}}};
  localparam logic signed [UPD_W-1:0] W_MIN = ~W_MAX;
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UPDATE = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_FILTER = 3'd3;
  localparam logic [2:0] S_OUTPUT = 3'd4;
  localparam logic [2:0] S_CLEAR  = 3'd5;

  if (NORM_MIN_LOG2 + MU_SHIFT < COEFF_FRAC) begin : g_bad_norm_floor
    $error("NORM_MIN_LOG2 + MU_SHIFT must be >= COEFF_FRAC");
  end
  if ((NUM_TAPS < 4) || (NUM_TAPS > 256) || ((NUM_TAPS & (NUM_TAPS - 1)) != 0)) begin : g_bad_taps
    $error("NUM_TAPS must be a power of two in 4..256");
  end

  logic [2:0]               state;
  logic [TAP_W-1:0]         cnt;
  logic [TAP_W-1:0]         wptr;
  logic signed [DATA_W-1:0] sbuf [NUM_TAPS];
  logic signed [COEFF_W-1:0] w_q [NUM_TAPS];
  logic signed [DATA_W-1:0] x_new;
  logic signed [DATA_W-1:0] e_cur;
  logic                     adapt_q;
  logic                     leak_q;
  logic                     clear_pend;
  logic [7:0]               shift_q;
  logic signed [ACC_W-1:0]  acc;

  // cnt runs N-1..0, so tap k = ~cnt and the regressor index
  // (wptr-1-k) mod N collapses to wptr+cnt.
  logic [TAP_W-1:0]          tap_k;
  logic [TAP_W-1:0]          x_idx;
  logic signed [DATA_W-1:0]  x_tap;
  logic signed [COEFF_W-1:0] w_tap;
  assign tap_k = ~cnt;
  assign x_idx = wptr + cnt;
  assign x_tap = sbuf[x_idx];
  assign w_tap = w_q[tap_k];

  logic [7:0] lz_calc;
  logic [7:0] shift_calc;
  always_comb begin
    lz_calc = 8'(NORM_MIN_LOG2);
    for (int i = 0; i < NORM_W; i++) begin
      if (norm_out[i] && (i > NORM_MIN_LOG2)) lz_calc = 8'(i);
    end
  end
  assign shift_calc = lz_calc + 8'(MU_SHIFT) - 8'(COEFF_FRAC);

  logic signed [PROD_W-1:0]  ex_prod;
  logic signed [PROD_W-1:0]  delta;
  logic signed [COEFF_W-1:0] w_leak;
  logic signed [UPD_W-1:0]   leak_term;
  logic signed [UPD_W-1:0]   w_next_wide;
  logic signed [COEFF_W-1:0] w_sat;
  logic                      w_clamp;
  assign ex_prod     = e_cur * x_tap;
  assign delta       = ex_prod >>> shift_q;
  assign w_leak      = w_tap >>> LEAK_SHIFT;
  assign leak_term   = leak_q ? UPD_W'(w_leak) : UPD_W'(0);
  assign w_next_wide = UPD_W'(w_tap) - leak_term + UPD_W'(delta);

  always_comb begin
    w_sat   = w_next_wide[COEFF_W-1:0];
    w_clamp = 1'b0;
    if (w_next_wide > W_MAX) begin
      w_sat   = W_MAX[COEFF_W-1:0];
      w_clamp = 1'b1;
    end else if (w_next_wide < W_MIN) begin
      w_sat   = W_MIN[COEFF_W-1:0];
      w_clamp = 1'b1;
    end
  end

  logic signed [MAC_W-1:0]  mac_prod;
  logic signed [ACC_W-1:0]  acc_shift;
  logic signed [DATA_W-1:0] y_sat;
  assign mac_prod  = w_tap * x_tap;
  assign acc_shift = acc >>> COEFF_FRAC;

  always_comb begin
    y_sat = acc_shift[DATA_W-1:0];
    if (acc_shift > Y_MAX)      y_sat = Y_MAX[DATA_W-1:0];
    else if (acc_shift < Y_MIN) y_sat = Y_MIN[DATA_W-1:0];
  end

  logic [PROD_W-1:0] sq_new;
  logic [PROD_W-1:0] sq_old;
  assign sq_new = x_new * x_new;
  assign sq_old = sbuf[wptr] * sbuf[wptr];

  assign busy_out = (state != S_IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= S_IDLE;
      cnt           <= '0;
      wptr          <= '0;
      x_new         <= '0;
      e_cur         <= '0;
      adapt_q       <= 1'b0;
      leak_q        <= 1'b0;
      clear_pend    <= 1'b0;
      shift_q       <= '0;
      acc           <= '0;
      y_out         <= '0;
      done_out      <= 1'b0;
      overrun_out   <= 1'b0;
      coeff_sat_out <= 1'b0;
      norm_out      <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        sbuf[i] <= '0;
        w_q[i]  <= '0;
      end
    end else begin
      done_out    <= 1'b0;
      overrun_out <= ready_in && (state != S_IDLE);
      // A request arriving during CLEAR merges into the clear already running.
      if (clear_in && (state != S_IDLE) && (state != S_CLEAR)) clear_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (ready_in) begin
            x_new      <= sample_in;
            e_cur      <= error_in;
            adapt_q    <= adapt_en_in;
            leak_q     <= leak_en_in;
            shift_q    <= shift_calc;
            clear_pend <= clear_in;
            cnt        <= '1;
            state      <= S_UPDATE;
          end else if (clear_in) begin
            cnt   <= '1;
            state <= S_CLEAR;
          end
        end
        S_UPDATE: begin
          if (adapt_q) begin
            w_q[tap_k] <= w_sat;
            if (w_clamp) coeff_sat_out <= 1'b1;
          end
          if (cnt == '0) state <= S_WRITE;
          else           cnt   <= cnt - 1'b1;
        end
        S_WRITE: begin
          norm_out   <= norm_out + NORM_W'(sq_new) - NORM_W'(sq_old);
          sbuf[wptr] <= x_new;
          wptr       <= wptr + 1'b1;
          acc        <= '0;
          cnt        <= '1;
          state      <= S_FILTER;
        end
        S_FILTER: begin
          acc <= acc + ACC_W'(mac_prod);
          if (cnt == '0) state <= S_OUTPUT;
          else           cnt   <= cnt - 1'b1;
        end
        S_OUTPUT: begin
          y_out    <= y_sat;
          done_out <= 1'b1;
          if (clear_pend || clear_in) begin
            clear_pend <= 1'b0;
            cnt        <= '1;
            state      <= S_CLEAR;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          w_q[tap_k]    <= '0;
          coeff_sat_out <= 1'b0;
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nlms_adaptive_filter.sv
// Directed bench for nlms_adaptive_filter: two 8-tap instances, one with default
// step/floor and one with MU_SHIFT=0, NORM_MIN_LOG2=14 for saturation cases.
module tb_nlms_adaptive_filter;

  logic clk;
  logic rst_a, rst_s, ready_a, ready_s;
  logic signed [15:0] sample, error;
  logic adapt_en, leak_en, clear;

  logic signed [15:0] y_a, y_s;
  logic done_a, busy_a, ov_a, sat_a;
  logic done_s, busy_s, ov_s, sat_s;
  logic [34:0] norm_a, norm_s;

  int checks = 0;
  int failures = 0;

  nlms_adaptive_filter #(.NUM_TAPS(8)) dut_a (
    .clk_in(clk), .rst_in(rst_a), .ready_in(ready_a), .sample_in(sample),
    .error_in(error), .adapt_en_in(adapt_en), .leak_en_in(leak_en), .clear_in(clear),
    .y_out(y_a), .done_out(done_a), .busy_out(busy_a), .overrun_out(ov_a),
    .coeff_sat_out(sat_a), .norm_out(norm_a)
  );

  nlms_adaptive_filter #(.NUM_TAPS(8), .MU_SHIFT(0), .NORM_MIN_LOG2(14)) dut_s (
    .clk_in(clk), .rst_in(rst_s), .ready_in(ready_s), .sample_in(sample),
    .error_in(error), .adapt_en_in(adapt_en), .leak_en_in(leak_en), .clear_in(clear),
    .y_out(y_s), .done_out(done_s), .busy_out(busy_s), .overrun_out(ov_s),
    .coeff_sat_out(sat_s), .norm_out(norm_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset(input bit a, input bit s);
    rst_a = a;
    rst_s = s;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    rst_s = 1'b0;
  endtask

  // Strobe one sample and wait (bounded) for done; called with the DUT idle.
  task automatic run_frame(input bit sel, input logic signed [15:0] x, input logic signed [15:0] e,
                           input logic ad, input logic lk, output int lat, output int busy_cnt);
    sample   = x;
    error    = e;
    adapt_en = ad;
    leak_en  = lk;
    if (sel) ready_s = 1'b1;
    else     ready_a = 1'b1;
    @(posedge clk); #1;
    ready_a  = 1'b0;
    ready_s  = 1'b0;
    lat      = 0;
    busy_cnt = (sel ? busy_s : busy_a) ? 1 : 0;
    while (!(sel ? done_s : done_a) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (sel ? busy_s : busy_a) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    do_reset(1'b1, 1'b1);
    checks++; if (y_a !== 16'sd0)   begin failures++; $display("FAIL reset_y got=%0d exp=0", y_a); end
    checks++; if (done_a !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done_a); end
    checks++; if (busy_a !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (ov_a !== 1'b0)    begin failures++; $display("FAIL reset_overrun got=%b exp=0", ov_a); end
    checks++; if (sat_a !== 1'b0)   begin failures++; $display("FAIL reset_sat got=%b exp=0", sat_a); end
    checks++; if (norm_a !== 35'd0) begin failures++; $display("FAIL reset_norm got=%0d exp=0", norm_a); end
  endtask

  task automatic test_latency;
    int lat, bc;
    run_frame(1'b0, 16'sd1000, 16'sd0, 1'b1, 1'b0, lat, bc);
    checks++; if (lat != 18)  begin failures++; $display("FAIL latency got=%0d exp=18", lat); end
    checks++; if (bc != 18)   begin failures++; $display("FAIL busy_cycles got=%0d exp=18", bc); end
    checks++; if (y_a !== 16'sd0) begin failures++; $display("FAIL latency_y got=%0d exp=0", y_a); end
    checks++; if (norm_a !== 35'd1000000) begin failures++; $display("FAIL latency_norm got=%0d exp=1000000", norm_a); end
    @(posedge clk); #1;
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done_a); end
  endtask

  task automatic test_adaptation(input logic ad, input logic signed [15:0] exp_y);
    int lat, bc;
    do_reset(1'b1, 1'b0);
    run_frame(1'b0, 16'sd8192, 16'sd0, ad, 1'b0, lat, bc);
    // Second strobe in the done cycle itself: back-to-back acceptance.
    run_frame(1'b0, 16'sd8192, 16'sd4096, ad, 1'b0, lat, bc);
    checks++; if (lat != 18) begin failures++; $display("FAIL adapt%0b_latency got=%0d exp=18", ad, lat); end
    checks++; if (y_a !== exp_y) begin failures++; $display("FAIL adapt%0b_y got=%0d exp=%0d", ad, y_a, exp_y); end
    checks++; if (norm_a !== 35'd134217728) begin failures++; $display("FAIL adapt%0b_norm got=%0d exp=134217728", ad, norm_a); end
    checks++; if (ov_a !== 1'b0) begin failures++; $display("FAIL adapt%0b_overrun got=%b exp=0", ad, ov_a); end
  endtask

  task automatic test_wrap;
    int lat, bc;
    do_reset(1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      run_frame(1'b0, 16'sd100, 16'sd0, 1'b1, 1'b0, lat, bc);
      if (i >= 8) begin
        checks++; if (norm_a !== 35'd80000) begin failures++; $display("FAIL wrap_norm frame=%0d got=%0d exp=80000", i, norm_a); end
      end
    end
    run_frame(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0, lat, bc);
    checks++; if (norm_a !== 35'd70000) begin failures++; $display("FAIL evict_norm got=%0d exp=70000", norm_a); end
  endtask

  task automatic test_overrun_clear;
    int lat, bc, ov, n;
    do_reset(1'b1, 1'b0);
    run_frame(1'b0, 16'sd8192, 16'sd0, 1'b1, 1'b0, lat, bc);
    run_frame(1'b0, 16'sd8192, 16'sd4096, 1'b1, 1'b0, lat, bc);
    sample = 16'sd8192; error = 16'sd0; adapt_en = 1'b0;
    ready_a = 1'b1;
    @(posedge clk); #1;
    ready_a = 1'b0;
    lat = 0; ov = 0;
    while (!done_a && lat < 100) begin
      if (lat == 11) begin
        ready_a = 1'b1;
        clear   = 1'b1;
        sample  = 16'sd30000;
      end
      @(posedge clk); #1;
      lat++;
      ready_a = 1'b0;
      clear   = 1'b0;
      if (ov_a) ov++;
    end
    checks++; if (lat != 18) begin failures++; $display("FAIL ovr_latency got=%0d exp=18", lat); end
    checks++; if (y_a !== 16'sd256) begin failures++; $display("FAIL ovr_y got=%0d exp=256", y_a); end
    checks++; if (norm_a !== 35'd201326592) begin failures++; $display("FAIL ovr_norm got=%0d exp=201326592", norm_a); end
    bc = 0; n = 0;
    while (busy_a && n < 50) begin
      bc++;
      @(posedge clk); #1;
      n++;
      if (ov_a) ov++;
    end
    checks++; if (ov != 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", ov); end
    checks++; if (bc != 8) begin failures++; $display("FAIL clear_cycles got=%0d exp=8", bc); end
    checks++; if (sat_a !== 1'b0) begin failures++; $display("FAIL clear_sat got=%b exp=0", sat_a); end
    run_frame(1'b0, 16'sd8192, 16'sd0, 1'b0, 1'b0, lat, bc);
    checks++; if (y_a !== 16'sd0) begin failures++; $display("FAIL cleared_y got=%0d exp=0", y_a); end
  endtask

  task automatic test_saturation;
    int lat, bc;
    do_reset(1'b0, 1'b1);
    run_frame(1'b1, 16'sd32767, 16'sd32767, 1'b1, 1'b0, lat, bc);
    checks++; if (y_s !== 16'sd0) begin failures++; $display("FAIL sat_f1_y got=%0d exp=0", y_s); end
    run_frame(1'b1, 16'sd32767, 16'sd32767, 1'b1, 1'b0, lat, bc);
    checks++; if (y_s !== 16'sd32767) begin failures++; $display("FAIL sat_f2_y got=%0d exp=32767", y_s); end
    checks++; if (sat_s !== 1'b0) begin failures++; $display("FAIL sat_f2_flag got=%b exp=0", sat_s); end
    run_frame(1'b1, 16'sd32767, 16'sd32767, 1'b1, 1'b0, lat, bc);
    checks++; if (sat_s !== 1'b1) begin failures++; $display("FAIL sat_f3_flag got=%b exp=1", sat_s); end
    checks++; if (y_s !== 16'sd32767) begin failures++; $display("FAIL sat_f3_y got=%0d exp=32767", y_s); end
    run_frame(1'b1, 16'sd32767, 16'sd0, 1'b0, 1'b0, lat, bc);
    checks++; if (sat_s !== 1'b1) begin failures++; $display("FAIL sat_sticky got=%b exp=1", sat_s); end
  endtask

  task automatic test_reset_mid;
    int lat, bc;
    sample = 16'sd500; error = 16'sd300; adapt_en = 1'b1;
    ready_s = 1'b1;
    @(posedge clk); #1;
    ready_s = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_s = 1'b1;
    @(posedge clk); #1;
    checks++; if (y_s !== 16'sd0)   begin failures++; $display("FAIL midrst_y got=%0d exp=0", y_s); end
    checks++; if (busy_s !== 1'b0)  begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy_s); end
    checks++; if (sat_s !== 1'b0)   begin failures++; $display("FAIL midrst_sat got=%b exp=0", sat_s); end
    checks++; if (norm_s !== 35'd0) begin failures++; $display("FAIL midrst_norm got=%0d exp=0", norm_s); end
    rst_s = 1'b0;
    run_frame(1'b1, 16'sd1000, 16'sd0, 1'b1, 1'b0, lat, bc);
    checks++; if (lat != 18) begin failures++; $display("FAIL postrst_latency got=%0d exp=18", lat); end
    checks++; if (norm_s !== 35'd1000000) begin failures++; $display("FAIL postrst_norm got=%0d exp=1000000", norm_s); end
  endtask

  initial begin
    rst_a = 1'b1; rst_s = 1'b1; ready_a = 1'b0; ready_s = 1'b0;
    sample = '0; error = '0; adapt_en = 1'b0; leak_en = 1'b0; clear = 1'b0;
    test_reset;
    test_latency;
    test_adaptation(1'b1, 16'sd256);
    test_adaptation(1'b0, 16'sd0);
    test_wrap;
    test_overrun_clear;
    test_saturation;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nlms_adaptive_filter.md
Name: nlms_adaptive_filter

Overview:
- Parametrised successor to the fixed 64-tap NLMS/FIR pair, merged into one sequential engine.
- Owns its circular sample buffer, its running energy norm, its coefficient store and its output accumulator.
- Per accepted sample, runs one NLMS coefficient update pass followed by one FIR pass.
- Sits after the lowpass stage; error_in is driven by the error calculator; y_out drives the speaker path.

Parameters:
- NUM_TAPS, 64, filter length; power of two, 4..256.
- DATA_W, 16, sample, error and output width (signed).
- COEFF_W, 16, coefficient width (signed, Q format).
- COEFF_FRAC, 14, fractional bits of a coefficient.
- MU_SHIFT, 4, step size mu = 2^-MU_SHIFT.
- NORM_MIN_LOG2, 20, floor on the log2(norm) used in normalisation. Elaboration-time check: NORM_MIN_LOG2+MU_SHIFT >= COEFF_FRAC.
- LEAK_SHIFT, 12, leakage term is w>>>LEAK_SHIFT.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous, active-high reset.
- ready_in  in  1  one-cycle strobe: new sample and error are valid.
- sample_in  in  DATA_W  new reference sample x(n+1).
- error_in  in  DATA_W  error e(n) for the previous output.
- adapt_en_in  in  1  0 freezes coefficients; sampled with ready_in.
- leak_en_in  in  1  enables leakage; sampled with ready_in.
- clear_in  in  1  request to zero all coefficients.
- y_out  out  DATA_W  filter output, saturated.
- done_out  out  1  one-cycle pulse when y_out updates.
- busy_out  out  1  high whenever not IDLE.
- overrun_out  out  1  one-cycle pulse per dropped ready_in.
- coeff_sat_out  out  1  sticky; set on any coefficient clamp; cleared by reset or clear.
- norm_out  out  2*DATA_W+log2(NUM_TAPS)  running sum of x^2 over the buffer.

Behaviour:
- Reset: takes priority over everything, including mid-frame.
  - Clears all outputs, the buffer, the coefficients, the norm, the write pointer and any pending clear.
  - Enters IDLE.
- States: IDLE, UPDATE, WRITE, FILTER, OUTPUT, CLEAR.
- IDLE + ready_in:
  - Capture sample, error, adapt_en and leak_en.
  - Latch lz = floor(log2(max(norm, 2^NORM_MIN_LOG2))).
  - Go to UPDATE with k=0.
- IDLE + clear_in (no ready_in): go to CLEAR. If both are high, ready_in wins and the clear is latched as pending.
- UPDATE (NUM_TAPS cycles, k=0..N-1):
  - Old regressor: x_old[k] = buf[(wptr-1-k) mod N].
  - If adapt_en is set: w[k] = sat(w[k] - (leak_en ? w[k]>>>LEAK_SHIFT : 0) + ((e*x_old[k]) >>> (lz+MU_SHIFT-COEFF_FRAC))).
  - Shifts are arithmetic (floor). sat clamps to the COEFF_W signed range and sets coeff_sat_out.
  - If adapt_en is clear, w[k] is unchanged and the cycle count is identical.
- WRITE (1 cycle):
  - norm += sample^2 - buf[wptr]^2 (the evicted sample).
  - buf[wptr] = sample; wptr = wptr+1 mod N.
- FILTER (NUM_TAPS cycles):
  - acc += w[k]*buf[(wptr-1-k) mod N].
  - acc width is DATA_W+COEFF_W+log2(N); no internal overflow.
- OUTPUT (1 cycle):
  - y_out = sat_DATA_W(acc >>> COEFF_FRAC); done_out=1.
  - Next state is CLEAR if a clear is pending, else IDLE.
- CLEAR (NUM_TAPS cycles):
  - Zero w[k] one per cycle; clear coeff_sat_out.
  - Buffer and norm are unaffected. Return to IDLE.
- Latency: the ready_in sampled at edge T0 yields y_out/done_out at edge T0+2N+2, i.e. done_out is visible in cycle 2N+2 after the strobe.
- Back-to-back: the next ready_in is accepted in the cycle after done_out, throughput 1 per 2N+3 cycles.
- ready_in while busy_out=1 (any non-IDLE state, including OUTPUT and CLEAR):
  - The sample is dropped and overrun_out pulses the next cycle.
  - The frame in progress is unaffected.
- clear_in while busy: latched as pending and executed after OUTPUT. Multiple requests merge into one.
- Storage: coefficients and buffer may be registers or single-port-per-cycle RAM, provided the cycle counts above hold exactly.

Test Plan:
- Latency/norm (N=8): reset, then ready_in with x=1000, e=0 → done_out exactly 18 cycles later, y_out=0, norm_out=1000000, busy_out high for cycles 1..18.
- Adaptation (N=8, defaults): frame1 x=8192, e=0; frame2 x=8192, e=4096, adapt_en=1 → lz=26, shift 16, w[0]=512, y_out=256, norm_out=2^27.
- Freeze: repeat the adaptation scenario with adapt_en=0 → y_out=0, w[0]=0, same latency.
- Wrap/evict (N=8): 9 frames of x=100, e=0 → norm_out=80000 after frames 8 and 9. Then one frame x=0 → norm_out=70000.
- Overrun/clear: ready_in and clear_in pulsed mid-FILTER → overrun_out pulses once, y_out unchanged by the dropped sample, CLEAR runs 8 cycles after OUTPUT, then all w=0 and coeff_sat_out=0.
- Saturation/reset: e=x=32767 repeatedly with MU_SHIFT=0, NORM_MIN_LOG2=14 → w[0] clamps at 32767, coeff_sat_out sticky, y_out clamps at 32767. rst_in mid-UPDATE → all outputs 0 next cycle, IDLE.
